bcd_to_bin: RTL

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin_pkg.sv | 29 ++
 rtl/bcd_to_bin_if.sv | 20 ++
 rtl/bcd_to_bin_nibble_adjust.sv | 11 +
 rtl/bcd_to_bin.sv | 110 +++++++++++
 4 files changed

// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   NDIG/BCD_W/BIN_W/NITER : digit count, field widths, shift iterations
//   state_e                : converter FSM states
//   digits_valid()         : 1 when every packed BCD nibble is 0..9
package bcd_to_bin_pkg;

  localparam int NDIG  = 4;
  localparam int BCD_W = 16;
  localparam int BIN_W = 14;
  localparam int NITER = 14;
  localparam int CNT_W = 4;
  localparam int WRK_W = BCD_W + BIN_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  function automatic logic digits_valid(input logic [BCD_W-1:0] bcd);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NDIG; i++)
      if (bcd[i*4 +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Request/response bundle for bcd_to_bin.
//   start : conversion request           (master -> slave)
//   bcd   : four packed BCD digits       (master -> slave)
//   bin   : binary result 0..9999        (slave -> master)
//   busy  : conversion in progress       (slave -> master)
//   done  : one-cycle result/err update  (slave -> master)
//   err   : last accepted request had a digit > 9
interface bcd_to_bin_if;
  import bcd_to_bin_pkg::*;

  logic             start;
  logic [BCD_W-1:0] bcd;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic             err;

  modport master (output start, output bcd, input bin, input busy, input done, input err);
  modport slave  (input start, input bcd, output bin, output busy, output done, output err);
endinterface

// File: rtl/bcd_to_bin_nibble_adjust.sv
// Reverse double-dabble digit correction: a nibble that reads >= 8 after
// the right shift gets 3 subtracted. Only applied to values >= 8, so the
// 4-bit subtraction never wraps.
//   nib_i : shifted BCD nibble
//   nib_o : corrected nibble
module bcd_nibble_adjust (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = nib_i[3] ? (nib_i - 4'd3) : nib_i;
endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit BCD to 14-bit binary converter (reverse double-dabble).
// One shift per cycle over a 30-bit {bcd, bin} working register.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : slave side of bcd_to_bin_if (start/bcd in, bin/busy/done/err out)
module bcd_to_bin
  import bcd_to_bin_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  bcd_to_bin_if.slave  bus
);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [WRK_W-1:0]       wrk_q;
  logic [BIN_W-1:0]       bin_q;
  logic                   err_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   bad_q;   // captured request holds a non-decimal digit

  // Datapath for one shift step: logical shift right, then correct each
  // BCD nibble in the upper field.
  logic [WRK_W-1:0]            wrk_shr;
  logic [WRK_W-1:0]            wrk_nxt;
  logic [NDIG-1:0][3:0]        nib_sh;
  logic [NDIG-1:0][3:0]        nib_adj;

  assign wrk_shr = wrk_q >> 1;
  assign nib_sh  = wrk_shr[WRK_W-1:BIN_W];

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .nib_i (nib_sh[g]),
      .nib_o (nib_adj[g])
    );
  end

  assign wrk_nxt = {nib_adj, wrk_shr[BIN_W-1:0]};

  // Valid conversions publish BIN and pulse Done on the last shift edge,
  // so the result is visible while in DONE. Invalid requests publish Err
  // and pulse Done on the edge leaving DONE, two edges after capture.
  // DONE accepts a held Start directly so back-to-back requests run at a
  // 16-cycle period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wrk_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            wrk_q   <= {bus.bcd, {BIN_W{1'b0}}};
            bad_q   <= ~digits_valid(bus.bcd);
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bad_q) begin
            state_q <= S_DONE;
          end else begin
            err_q   <= 1'b0;
            cnt_q   <= CNT_W'(NITER);
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          wrk_q <= wrk_nxt;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            bin_q   <= wrk_nxt[BIN_W-1:0];
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (bad_q) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end
          if (bus.start) begin
            wrk_q   <= {bus.bcd, {BIN_W{1'b0}}};
            bad_q   <= ~digits_valid(bus.bcd);
            state_q <= S_LOAD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.bin  = bin_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule
